// File: rtl/flat_array_shift_queue_pkg.sv
// Shared types and sizing helpers for the flat-array shift queue.
// Each slot receives one operation code per clock edge.
package flat_array_shift_queue_pkg;

    typedef enum logic [1:0] {
        SLOT_HOLD      = 2'd0,
        SLOT_LOAD_NEXT = 2'd1,
        SLOT_LOAD_PUSH = 2'd2,
        SLOT_CLEAR     = 2'd3
    } slot_op_e;

    // The count has to represent 0..entries inclusive.
    function automatic int count_width(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/flat_array_shift_queue_if.sv
// Push/pop handshake and flat-array status bundle for the shift queue.
// The slave modport is the queue; the master modport is the producer/consumer side.
interface flat_array_shift_queue_if
    import flat_array_shift_queue_pkg::*;
#(
    parameter int ARRAY_SIZE  = 4,
    parameter int SIGNAL_SIZE = 8
);

    localparam int COUNT_W = count_width(ARRAY_SIZE);

    logic                              flush;
    logic                              push_valid;
    logic [SIGNAL_SIZE-1:0]            push_data;
    logic                              push_ready;
    logic                              pop_valid;
    logic                              pop_ready;
    logic [SIGNAL_SIZE-1:0]            pop_data;
    logic [SIGNAL_SIZE*ARRAY_SIZE-1:0] entries_flat;
    logic [ARRAY_SIZE-1:0]             valid_mask;
    logic [COUNT_W-1:0]                count;

    modport slave (
        input  flush,
        input  push_valid,
        input  push_data,
        input  pop_ready,
        output push_ready,
        output pop_valid,
        output pop_data,
        output entries_flat,
        output valid_mask,
        output count
    );

    modport master (
        output flush,
        output push_valid,
        output push_data,
        output pop_ready,
        input  push_ready,
        input  pop_valid,
        input  pop_data,
        input  entries_flat,
        input  valid_mask,
        input  count
    );

endinterface

// File: rtl/flat_array_shift_queue_slot.sv
// One queue entry: a SIGNAL_SIZE register that can take its upper neighbour,
// the push data, zero, or hold, as selected by the queue control.
module flat_array_shift_queue_slot
    import flat_array_shift_queue_pkg::*;
#(
    parameter int SIGNAL_SIZE = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  slot_op_e               op_i,
    input  logic [SIGNAL_SIZE-1:0] next_i,
    input  logic [SIGNAL_SIZE-1:0] push_i,
    output logic [SIGNAL_SIZE-1:0] data_o
);

    logic [SIGNAL_SIZE-1:0] data_q;
    logic [SIGNAL_SIZE-1:0] data_d;

    always_comb begin
        data_d = data_q;
        unique case (op_i)
            SLOT_HOLD:      data_d = data_q;
            SLOT_LOAD_NEXT: data_d = next_i;
            SLOT_LOAD_PUSH: data_d = push_i;
            SLOT_CLEAR:     data_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/flat_array_shift_queue.sv
// In-order shift queue with the oldest entry at index 0 and every entry exposed
// on a flat bus for the decode/issue windows downstream.
`ifndef FLAT_ARRAY_MACROS
`define FLAT_ARRAY_MACROS
`define ARRAY(name, width, size) logic [(width)-1:0] name [(size)]
`define FLAT_ARRAY(name, width, size) logic [(width)*(size)-1:0] name
`define FLAT_EQUALS_NORMAL(flat, normal, width, size) \
    generate for (flatten_i = 0; flatten_i < (size); flatten_i = flatten_i + 1) begin : g_flatten \
        assign flat[flatten_i*(width) +: (width)] = normal[flatten_i]; \
    end endgenerate
`define NORMAL_EQUALS_FLAT(normal, flat, width, size) \
    generate for (flatten_i = 0; flatten_i < (size); flatten_i = flatten_i + 1) begin : g_unflatten \
        assign normal[flatten_i] = flat[flatten_i*(width) +: (width)]; \
    end endgenerate
`endif

module flat_array_shift_queue
    import flat_array_shift_queue_pkg::*;
#(
    parameter int ARRAY_SIZE  = 4,
    parameter int SIGNAL_SIZE = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    flat_array_shift_queue_if.slave   q_if
);

    localparam int                 COUNT_W    = count_width(ARRAY_SIZE);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(ARRAY_SIZE);

    logic [COUNT_W-1:0]    count_q;
    logic [COUNT_W-1:0]    count_d;
    logic                  push_ready;
    logic                  pop_valid;
    logic                  push_fire;
    logic                  pop_fire;
    logic [ARRAY_SIZE-1:0] valid_mask;

    `ARRAY(entries, SIGNAL_SIZE, ARRAY_SIZE);
    `FLAT_ARRAY(entries_flat, SIGNAL_SIZE, ARRAY_SIZE);
    genvar flatten_i;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ready = (count_q < FULL_COUNT) | q_if.pop_ready;
    assign pop_valid  = (count_q != '0);
    assign push_fire  = q_if.push_valid & push_ready;
    assign pop_fire   = pop_valid & q_if.pop_ready;

    always_comb begin
        count_d = count_q;
        if (q_if.flush) begin
            count_d = '0;
        end else if (push_fire && !pop_fire) begin
            count_d = count_q + COUNT_W'(1);
        end else if (pop_fire && !push_fire) begin
            count_d = count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_slot
        localparam logic [COUNT_W-1:0] SLOT_IDX = COUNT_W'(i);
        localparam logic [COUNT_W-1:0] SLOT_END = COUNT_W'(i + 1);

        logic [SIGNAL_SIZE-1:0] next_data;
        slot_op_e               op;

        if (i == ARRAY_SIZE - 1) begin : g_tail
            assign next_data = '0;
        end else begin : g_body
            assign next_data = entries[i+1];
        end

        // Slots past the tail are zero, so shifting every slot on a pop also clears the vacated one.
        always_comb begin
            op = SLOT_HOLD;
            if (q_if.flush) begin
                op = SLOT_CLEAR;
            end else if (pop_fire) begin
                if (push_fire && (count_q == SLOT_END)) begin
                    op = SLOT_LOAD_PUSH;
                end else begin
                    op = SLOT_LOAD_NEXT;
                end
            end else if (push_fire && (count_q == SLOT_IDX)) begin
                op = SLOT_LOAD_PUSH;
            end
        end

        flat_array_shift_queue_slot #(
            .SIGNAL_SIZE (SIGNAL_SIZE)
        ) u_slot (
            .clock  (clock),
            .reset  (reset),
            .op_i   (op),
            .next_i (next_data),
            .push_i (q_if.push_data),
            .data_o (entries[i])
        );

        assign valid_mask[i] = (count_q > SLOT_IDX);
    end

    `FLAT_EQUALS_NORMAL(entries_flat, entries, SIGNAL_SIZE, ARRAY_SIZE)

    assign q_if.push_ready   = push_ready;
    assign q_if.pop_valid    = pop_valid;
    assign q_if.pop_data     = entries[0];
    assign q_if.entries_flat = entries_flat;
    assign q_if.valid_mask   = valid_mask;
    assign q_if.count        = count_q;

endmodule

// File: tb/tb_flat_array_shift_queue.sv
// Bench for flat_array_shift_queue: directed scenarios with hand-computed values
// plus a queue scoreboard compared against the DUT on every falling edge.
module tb_flat_array_shift_queue;

    localparam int AS = 4;
    localparam int SS = 8;
    localparam int CW = $clog2(AS + 1);

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    flat_array_shift_queue_if #(.ARRAY_SIZE(AS), .SIGNAL_SIZE(SS)) q_if ();

    flat_array_shift_queue #(
        .ARRAY_SIZE  (AS),
        .SIGNAL_SIZE (SS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .q_if  (q_if)
    );

    logic [SS-1:0] sb_q[$];
    logic [SS-1:0] popped_q[$];
    int            checks   = 0;
    int            failures = 0;
    bit            mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, input logic fl, input logic pv,
                         input logic [SS-1:0] pd, input logic pr);
        reset           = rs;
        q_if.flush      = fl;
        q_if.push_valid = pv;
        q_if.push_data  = pd;
        q_if.pop_ready  = pr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference queue: accepted pushes are appended, pops remove the front.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (reset || q_if.flush) begin
            sb_q.delete();
        end else begin
            do_pop  = (sb_q.size() != 0) && q_if.pop_ready;
            do_push = q_if.push_valid && ((sb_q.size() < AS) || q_if.pop_ready);
            if (do_pop) void'(sb_q.pop_front());
            if (do_push) sb_q.push_back(q_if.push_data);
        end
    endtask

    task automatic monitor_step();
        logic [SS*AS-1:0] e_flat;
        logic [AS-1:0]    e_mask;
        logic [SS-1:0]    e_head;
        e_flat = '0;
        e_mask = '0;
        for (int i = 0; i < sb_q.size(); i++) begin
            e_flat[i*SS +: SS] = sb_q[i];
            e_mask[i]          = 1'b1;
        end
        e_head = (sb_q.size() != 0) ? sb_q[0] : '0;
        chk("mon_count", 64'(q_if.count), 64'(sb_q.size()));
        chk("mon_valid_mask", 64'(q_if.valid_mask), 64'(e_mask));
        chk("mon_entries_flat", 64'(q_if.entries_flat), 64'(e_flat));
        chk("mon_pop_valid", 64'(q_if.pop_valid), 64'(sb_q.size() != 0));
        chk("mon_push_ready", 64'(q_if.push_ready), 64'((sb_q.size() < AS) || q_if.pop_ready));
        chk("mon_pop_data", 64'(q_if.pop_data), 64'(e_head));
        if (q_if.pop_valid && q_if.pop_ready && !reset && !q_if.flush)
            popped_q.push_back(q_if.pop_data);
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (mon_en) monitor_step();
    end

    initial begin
        logic [SS-1:0] exp_pops [4];
        exp_pops = '{8'h22, 8'h33, 8'h44, 8'h55};

        // Reset with a push offered
        drive(1'b1, 1'b0, 1'b1, 8'h99, 1'b0);
        tick();
        chk("rst_count", 64'(q_if.count), 64'd0);
        chk("rst_valid_mask", 64'(q_if.valid_mask), 64'h0);
        chk("rst_entries_flat", 64'(q_if.entries_flat), 64'h0);
        chk("rst_push_ready", 64'(q_if.push_ready), 64'd1);
        chk("rst_pop_valid", 64'(q_if.pop_valid), 64'd0);
        mon_en = 1'b1;

        // Fill to capacity
        drive(1'b0, 1'b0, 1'b1, 8'h11, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'h22, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'h33, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'h44, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); #1;
        chk("full_count", 64'(q_if.count), 64'd4);
        chk("full_entries_flat", 64'(q_if.entries_flat), 64'h44332211);
        chk("full_valid_mask", 64'(q_if.valid_mask), 64'hF);
        chk("full_push_ready", 64'(q_if.push_ready), 64'd0);

        // Push into a full queue without pop_ready is ignored
        drive(1'b0, 1'b0, 1'b1, 8'h66, 1'b0); tick();
        chk("full_hold_flat", 64'(q_if.entries_flat), 64'h44332211);
        chk("full_hold_count", 64'(q_if.count), 64'd4);

        // Full pass-through: push 0x55 while popping 0x11
        drive(1'b0, 1'b0, 1'b1, 8'h55, 1'b1); #1;
        chk("pass_pop_data", 64'(q_if.pop_data), 64'h11);
        chk("pass_push_ready", 64'(q_if.push_ready), 64'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); #1;
        chk("pass_entries_flat", 64'(q_if.entries_flat), 64'h55443322);
        chk("pass_count", 64'(q_if.count), 64'd4);

        // Drain, then one more pop_ready on an empty queue
        popped_q.delete();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (4) tick();
        chk("drain_pop_valid", 64'(q_if.pop_valid), 64'd0);
        chk("drain_entries_flat", 64'(q_if.entries_flat), 64'h0);
        chk("drain_pop_count", 64'(popped_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < popped_q.size()) chk($sformatf("drain_order_%0d", i), 64'(popped_q[i]), 64'(exp_pops[i]));
            else chk($sformatf("drain_order_%0d", i), 64'hDEAD, 64'(exp_pops[i]));
        end
        tick();
        chk("empty_pop_count", 64'(q_if.count), 64'd0);
        chk("empty_pop_flat", 64'(q_if.entries_flat), 64'h0);
        chk("empty_pop_popped", 64'(popped_q.size()), 64'd4);

        // Flush with simultaneous push and pop
        drive(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'hBB, 1'b0); tick();
        chk("preflush_count", 64'(q_if.count), 64'd2);
        chk("preflush_flat", 64'(q_if.entries_flat), 64'h0000BBAA);
        drive(1'b0, 1'b1, 1'b1, 8'hCC, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); #1;
        chk("flush_count", 64'(q_if.count), 64'd0);
        chk("flush_flat", 64'(q_if.entries_flat), 64'h0);
        chk("flush_pop_valid", 64'(q_if.pop_valid), 64'd0);

        // Reset beats push and pop
        drive(1'b0, 1'b0, 1'b1, 8'h01, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'h02, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'h03, 1'b0); tick();
        chk("prerst_count", 64'(q_if.count), 64'd3);
        chk("prerst_flat", 64'(q_if.entries_flat), 64'h00030201);
        drive(1'b1, 1'b0, 1'b1, 8'h04, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); #1;
        chk("rst2_count", 64'(q_if.count), 64'd0);
        chk("rst2_valid_mask", 64'(q_if.valid_mask), 64'h0);
        chk("rst2_entries_flat", 64'(q_if.entries_flat), 64'h0);
        chk("rst2_pop_data", 64'(q_if.pop_data), 64'h0);
        chk("rst2_pop_valid", 64'(q_if.pop_valid), 64'd0);
        chk("rst2_push_ready", 64'(q_if.push_ready), 64'd1);

        // Random traffic, alternating consumer pressure to reach full and empty
        for (int n = 0; n < 10000; n++) begin
            int thr;
            thr = ((n / 500) % 2 == 0) ? 1 : 3;
            drive($urandom_range(0, 255) == 0,
                  $urandom_range(0, 63) == 0,
                  $urandom_range(0, 1) == 1,
                  8'($urandom),
                  $urandom_range(0, 3) < thr);
            tick();
        end

        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
